mem_bus_initiator: RTL

Synthesizable initiator for the strobe-based memory bus (start, write, addr, bidirectional data) served by the existing memory responder. Accepts read/write commands over a valid/ready interface and sequences them onto the bus with programmable setup and strobe timing. Read data is returned on a valid/ready response channel. The bidirectional data bus is split into data_o, data_oe and data_i, with the tristate buffer at the top level.

---
 rtl/mem_bus_initiator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_bus_initiator.sv
// Strobe-bus initiator: valid/ready commands are sequenced into registered start/write/addr/data phases.
// Optional MEM_BUS_INITIATOR_STATS_EN adds saturating wr_count/rd_count outputs.
module mem_bus_initiator #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              start,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_i
`ifdef MEM_BUS_INITIATOR_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_d, write_d, data_oe_d, rsp_valid_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_o_d, rsp_data_d;
  logic              strobe_done;

  assign cmd_ready   = (state_q == IDLE) && !rsp_valid;
  assign strobe_done = (state_q == STROBE) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    write_d     = write;
    addr_d      = addr;
    data_o_d    = data_o;
    data_oe_d   = data_oe;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;

    if (rsp_valid && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          write_d   = cmd_write;
          addr_d    = cmd_addr;
          data_o_d  = cmd_wdata;
          data_oe_d = cmd_write;
          cnt_d     = CNT_W'(SETUP_CYC - 1);
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(STROBE_CYC - 1);
          start_d = 1'b1;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          // Read data is captured while the responder is still driving the bus.
          if (!write) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_i;
          end
        end else begin
          cnt_d   = cnt_q - 1'b1;
          start_d = 1'b1;
        end
      end
      RECOVER: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start     <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      data_o    <= '0;
      data_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start     <= start_d;
      write     <= write_d;
      addr      <= addr_d;
      data_o    <= data_o_d;
      data_oe   <= data_oe_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
    end
  end

`ifdef MEM_BUS_INITIATOR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (strobe_done) begin
      if (write && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      if (!write && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
